// File: rtl/dac_audio_sequencer_if.sv
// Audio sources, mute request and DAC-side outputs of the sequencer.
interface dac_audio_sequencer_if #(
    parameter int MSBI = 15
);
    logic            enable;
    logic [MSBI:0]   a_data;
    logic            a_valid;
    logic [MSBI:0]   b_data;
    logic            b_valid;
    logic [MSBI:0]   dac_value;
    logic            dac_cen;
    logic            muted;
    logic [1:0]      overrun;

    // Producer / control side: drives samples and the mute request.
    modport master (
        output enable, a_data, a_valid, b_data, b_valid,
        input  dac_value, dac_cen, muted, overrun
    );

    // Sequencer side.
    modport slave (
        input  enable, a_data, a_valid, b_data, b_valid,
        output dac_value, dac_cen, muted, overrun
    );
endinterface

// File: rtl/dac_audio_sequencer.sv
// Mixes two signed audio sources at a fixed sample tick, applies a soft-mute
// gain ramp and presents an offset-binary value plus strobe to the DAC.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | muted, gain 0, DAC held at midscale
// RAMP_UP   | gain climbing one step per tick toward 256
// RUN       | full gain 256, mix passed through unchanged
// RAMP_DOWN | gain falling one step per tick toward 0
module dac_audio_sequencer #(
    parameter int MSBI = 15,
    parameter int DIV  = 1125
) (
    input  logic                 clk,
    input  logic                 reset,
    dac_audio_sequencer_if.slave bus
);
    localparam int W  = MSBI + 1;
    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, RAMP_UP, RUN, RAMP_DOWN} state_t;

    state_t                state;
    state_t                state_next;
    logic [8:0]            gain;
    logic [8:0]            gain_next;
    logic [CW-1:0]         count;
    logic                  tick;
    logic [MSBI:0]         hold_a;
    logic [MSBI:0]         hold_b;
    logic                  fresh_a;
    logic                  fresh_b;
    logic signed [W:0]     sum;
    logic signed [W-1:0]   mix;
    logic signed [W+9:0]   product;
    logic signed [W-1:0]   scaled;
    logic                  unused_bits;

    assign tick = (count == CW'(DIV - 1));

    // Sample-rate counter: 0..DIV-1, tick on the last count.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    // Holding registers, freshness flags and sticky overrun detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_a      <= '0;
            hold_b      <= '0;
            fresh_a     <= 1'b0;
            fresh_b     <= 1'b0;
            bus.overrun <= 2'b00;
        end else begin
            if (bus.a_valid) begin
                hold_a  <= bus.a_data;
                fresh_a <= 1'b1;
            end else if (tick) begin
                fresh_a <= 1'b0;
            end
            if (bus.b_valid) begin
                hold_b  <= bus.b_data;
                fresh_b <= 1'b1;
            end else if (tick) begin
                fresh_b <= 1'b0;
            end
            // A second sample before the previous one was consumed is lost.
            if (bus.a_valid && fresh_a && !tick) begin
                bus.overrun[0] <= 1'b1;
            end
            if (bus.b_valid && fresh_b && !tick) begin
                bus.overrun[1] <= 1'b1;
            end
        end
    end

    // Ramp decision for the current tick; a direction reversal holds gain.
    always_comb begin
        state_next = state;
        gain_next  = gain;
        unique case (state)
            IDLE: begin
                if (bus.enable) state_next = RAMP_UP;
            end
            RAMP_UP: begin
                if (bus.enable) begin
                    gain_next = gain + 9'd1;
                    if (gain == 9'd255) state_next = RUN;
                end else begin
                    state_next = RAMP_DOWN;
                end
            end
            RUN: begin
                if (!bus.enable) state_next = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                if (!bus.enable) begin
                    gain_next = gain - 9'd1;
                    if (gain == 9'd1) state_next = IDLE;
                end else begin
                    state_next = RAMP_UP;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Mix with floor halving, then scale by the post-update gain.
    always_comb begin
        sum         = {hold_a[MSBI], hold_a} + {hold_b[MSBI], hold_b};
        mix         = sum[W:1];
        product     = mix * $signed({1'b0, gain_next});
        scaled      = product[W+7:8];
        unused_bits = ^{sum[0], product[W+9:W+8], product[7:0]};
    end

    // Sequencer state, gain and registered DAC outputs, all advanced on tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            gain          <= 9'd0;
            bus.dac_value <= {1'b1, {MSBI{1'b0}}};
            bus.dac_cen   <= 1'b0;
            bus.muted     <= 1'b1;
        end else begin
            bus.dac_cen <= tick;
            if (tick) begin
                state         <= state_next;
                gain          <= gain_next;
                bus.muted     <= (state_next == IDLE);
                bus.dac_value <= {~scaled[MSBI], scaled[MSBI-1:0]};
            end
        end
    end
endmodule

// File: tb/tb_dac_audio_sequencer.sv
// Self-checking bench for dac_audio_sequencer with a short tick period.
module tb_dac_audio_sequencer;
    localparam int MSBI = 15;
    localparam int DIV  = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] exp_q[$];

    // Reference model state
    int          m_cnt = 0;
    int          m_state = 0;
    int          m_gain = 0;
    logic [15:0] m_ha = '0;
    logic [15:0] m_hb = '0;

    always #5 clk = ~clk;

    dac_audio_sequencer_if #(.MSBI(MSBI)) bus ();

    dac_audio_sequencer #(.MSBI(MSBI), .DIV(DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Reference model: predicts each tick's DAC value and queues it.
    always @(posedge clk) begin
        int mixv;
        int scaledv;
        if (reset) begin
            m_cnt = 0; m_state = 0; m_gain = 0; m_ha = '0; m_hb = '0;
            exp_q.delete();
        end else begin
            if (m_cnt == DIV - 1) begin
                m_cnt = 0;
                case (m_state)
                    0: if (bus.enable) m_state = 1;
                    1: if (bus.enable) begin
                           m_gain = m_gain + 1;
                           if (m_gain == 256) m_state = 2;
                       end else m_state = 3;
                    2: if (!bus.enable) m_state = 3;
                    default: if (!bus.enable) begin
                           m_gain = m_gain - 1;
                           if (m_gain == 0) m_state = 0;
                       end else m_state = 1;
                endcase
                mixv    = (int'($signed(m_ha)) + int'($signed(m_hb))) >>> 1;
                scaledv = (mixv * m_gain) >>> 8;
                exp_q.push_back(16'(scaledv) ^ 16'h8000);
            end else begin
                m_cnt = m_cnt + 1;
            end
            if (bus.a_valid) m_ha = bus.a_data;
            if (bus.b_valid) m_hb = bus.b_data;
        end
    end

    // Scoreboard: every strobe must match the next predicted value.
    always @(negedge clk) begin
        logic [15:0] e;
        if (!reset) begin
            if (bus.dac_cen === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_cen: dac_value=%h, no tick predicted", bus.dac_value);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.dac_value !== e) begin
                        errors++;
                        $display("FAIL sb_value: got %h expected %h", bus.dac_value, e);
                    end
                end
            end else if (exp_q.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL sb_missing_cen: dac_cen=%b, %0d predicted values pending", bus.dac_cen, exp_q.size());
                exp_q.delete();
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    task automatic wait_cen();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.dac_cen !== 1'b1 && n < 3 * DIV);
        if (bus.dac_cen !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_cen: no strobe within %0d cycles, dac_cen=%b", n, bus.dac_cen);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bit exp_cen;
        @(negedge clk);
        checks++;
        if (bus.dac_value !== 16'h8000 || bus.dac_cen !== 1'b0 || bus.muted !== 1'b1 || bus.overrun !== 2'b00) begin
            errors++;
            $display("FAIL reset_values: value=%h cen=%b muted=%b overrun=%b expected 8000/0/1/00",
                     bus.dac_value, bus.dac_cen, bus.muted, bus.overrun);
        end
        reset = 1'b0;
        for (int c = 2; c <= 13; c++) begin
            @(negedge clk);
            exp_cen = (c >= 5) && ((c - 5) % DIV == 0);
            checks++;
            if (bus.dac_cen !== exp_cen) begin
                errors++;
                $display("FAIL tick_cadence: cycle %0d dac_cen=%b expected %b", c, bus.dac_cen, exp_cen);
            end
            if (c == 5) begin
                checks++;
                if (bus.dac_value !== 16'h8000 || bus.muted !== 1'b1 || bus.overrun !== 2'b00) begin
                    errors++;
                    $display("FAIL idle_tick: value=%h muted=%b overrun=%b expected 8000/1/00",
                             bus.dac_value, bus.muted, bus.overrun);
                end
            end
        end
    endtask

    task automatic test_ramp_up();
        do_reset();
        bus.enable = 1'b1;
        bus.a_data = 16'h4000; bus.b_data = 16'h4000;
        bus.a_valid = 1'b1; bus.b_valid = 1'b1;
        @(negedge clk);
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        for (int i = 1; i <= 258; i++) begin
            wait_cen();
            if (i == 1 || i == 2 || i == 129 || i == 257 || i == 258) begin
                logic [15:0] e;
                e = (i == 1) ? 16'h8000 : (i == 2) ? 16'h8040 : (i == 129) ? 16'hA000 : 16'hC000;
                checks++;
                if (bus.dac_value !== e) begin
                    errors++;
                    $display("FAIL ramp_up_tick%0d: got %h expected %h", i, bus.dac_value, e);
                end
            end
            if (i == 257) begin
                checks++;
                if (bus.muted !== 1'b0) begin
                    errors++;
                    $display("FAIL ramp_up_muted: got %b expected 0", bus.muted);
                end
            end
        end
    endtask

    task automatic test_mix();
        logic [15:0] va[4] = '{16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF};
        logic [15:0] vb[4] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h0000};
        logic [15:0] ve[4] = '{16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF};
        for (int k = 0; k < 4; k++) begin
            bus.a_data = va[k]; bus.b_data = vb[k];
            bus.a_valid = 1'b1; bus.b_valid = 1'b1;
            @(negedge clk);
            bus.a_valid = 1'b0; bus.b_valid = 1'b0;
            wait_cen();
            checks++;
            if (bus.dac_value !== ve[k]) begin
                errors++;
                $display("FAIL mix_%0d: a=%h b=%h got %h expected %h", k, va[k], vb[k], bus.dac_value, ve[k]);
            end
        end
    endtask

    task automatic test_overrun();
        bus.a_data = 16'h0002; bus.a_valid = 1'b1;
        @(negedge clk);
        bus.a_valid = 1'b0;
        repeat (2) @(negedge clk);
        bus.a_data = 16'h0100; bus.a_valid = 1'b1;
        @(negedge clk);
        bus.a_valid = 1'b0;
        checks++;
        if (bus.dac_cen !== 1'b1 || bus.dac_value !== 16'h8001) begin
            errors++;
            $display("FAIL coincident_old_sample: cen=%b value=%h expected 1/8001", bus.dac_cen, bus.dac_value);
        end
        checks++;
        if (bus.overrun !== 2'b00) begin
            errors++;
            $display("FAIL coincident_no_overrun: got %b expected 00", bus.overrun);
        end
        wait_cen();
        checks++;
        if (bus.dac_value !== 16'h8080) begin
            errors++;
            $display("FAIL coincident_new_sample: got %h expected 8080", bus.dac_value);
        end
        bus.a_valid = 1'b1;
        repeat (2) @(negedge clk);
        bus.a_valid = 1'b0;
        checks++;
        if (bus.overrun !== 2'b01) begin
            errors++;
            $display("FAIL overrun_set: got %b expected 01", bus.overrun);
        end
        wait_cen();
        wait_cen();
        checks++;
        if (bus.overrun !== 2'b01) begin
            errors++;
            $display("FAIL overrun_sticky: got %b expected 01", bus.overrun);
        end
    endtask

    task automatic test_reversal();
        do_reset();
        bus.enable = 1'b1;
        bus.a_data = 16'h4000; bus.b_data = 16'h4000;
        bus.a_valid = 1'b1; bus.b_valid = 1'b1;
        @(negedge clk);
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        for (int i = 1; i <= 203; i++) begin
            wait_cen();
            if (i == 101 || i == 102 || i == 201 || i == 202 || i == 203) begin
                logic [15:0] e;
                logic        em;
                e  = (i <= 102) ? 16'h9900 : (i == 201) ? 16'h8040 : 16'h8000;
                em = (i >= 202);
                checks++;
                if (bus.dac_value !== e || bus.muted !== em) begin
                    errors++;
                    $display("FAIL reversal_tick%0d: value=%h muted=%b expected %h/%b",
                             i, bus.dac_value, bus.muted, e, em);
                end
            end
            if (i == 101) bus.enable = 1'b0;
        end
    endtask

    task automatic test_reset_mid_ramp();
        do_reset();
        bus.enable = 1'b1;
        bus.a_data = 16'h4000; bus.b_data = 16'h4000;
        bus.a_valid = 1'b1; bus.b_valid = 1'b1;
        @(negedge clk);
        bus.a_valid = 1'b0;
        @(negedge clk);
        bus.b_valid = 1'b0;
        for (int i = 1; i <= 102; i++) begin
            wait_cen();
            if (i == 81) bus.enable = 1'b0;
        end
        checks++;
        if (bus.dac_value !== 16'h8F00 || bus.overrun !== 2'b10) begin
            errors++;
            $display("FAIL pre_reset_gain60: value=%h overrun=%b expected 8F00/10", bus.dac_value, bus.overrun);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.muted !== 1'b1 || bus.dac_value !== 16'h8000 || bus.overrun !== 2'b00 || bus.dac_cen !== 1'b0) begin
            errors++;
            $display("FAIL mid_ramp_reset: muted=%b value=%h overrun=%b cen=%b expected 1/8000/00/0",
                     bus.muted, bus.dac_value, bus.overrun, bus.dac_cen);
        end
        reset = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            checks++;
            if (bus.dac_cen !== (c == 5)) begin
                errors++;
                $display("FAIL restart_cadence: cycle %0d dac_cen=%b expected %b", c, bus.dac_cen, (c == 5));
            end
        end
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.a_data = '0; bus.a_valid = 1'b0;
        bus.b_data = '0; bus.b_valid = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_ramp_up();
        test_mix();
        test_overrun();
        test_reversal();
        test_reset_mid_ramp();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
